// File: rtl/tl_source_remapper_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// tl_channel : TileLink A/B/C/D/E channel bundle with host/device modports
// Rev 1.0
//------------------------------------------------------------------------------
interface tl_channel #(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 64,
  parameter int SizeWidth   = 3,
  parameter int SourceWidth = 8,
  parameter int SinkWidth   = 1
);
  logic                     a_valid, a_ready, a_corrupt;
  logic [2:0]               a_opcode, a_param;
  logic [SizeWidth-1:0]     a_size;
  logic [SourceWidth-1:0]   a_source;
  logic [AddrWidth-1:0]     a_address;
  logic [DataWidth/8-1:0]   a_mask;
  logic [DataWidth-1:0]     a_data;

  logic                     b_valid, b_ready, b_corrupt;
  logic [2:0]               b_opcode, b_param;
  logic [SizeWidth-1:0]     b_size;
  logic [SourceWidth-1:0]   b_source;
  logic [AddrWidth-1:0]     b_address;
  logic [DataWidth/8-1:0]   b_mask;
  logic [DataWidth-1:0]     b_data;

  logic                     c_valid, c_ready, c_corrupt;
  logic [2:0]               c_opcode, c_param;
  logic [SizeWidth-1:0]     c_size;
  logic [SourceWidth-1:0]   c_source;
  logic [AddrWidth-1:0]     c_address;
  logic [DataWidth-1:0]     c_data;

  logic                     d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]               d_opcode;
  logic [1:0]               d_param;
  logic [SizeWidth-1:0]     d_size;
  logic [SourceWidth-1:0]   d_source;
  logic [SinkWidth-1:0]     d_sink;
  logic [DataWidth-1:0]     d_data;

  logic                     e_valid, e_ready;
  logic [SinkWidth-1:0]     e_sink;

  modport host (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
    output b_ready,
    output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
    input  c_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready,
    output e_valid, e_sink,
    input  e_ready
  );

  modport device (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
    input  b_ready,
    input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
    output c_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready,
    input  e_valid, e_sink,
    output e_ready
  );
endinterface
`default_nettype wire

// File: rtl/tl_source_remapper.sv
`default_nettype none
//------------------------------------------------------------------------------
// tl_source_remapper : maps host source IDs onto a small pool of device IDs
// Rev 1.0
//------------------------------------------------------------------------------
module tl_source_remapper #(
  parameter int HostSourceWidth   = 8,
  parameter int DeviceSourceWidth = 3,
  parameter int NumSlots          = 1 << DeviceSourceWidth,
  parameter int SourceBase        = 0,
  parameter int DataWidth         = 64,
  parameter int SizeWidth         = 3
) (
  input  wire         clk_i,
  input  wire         rst_ni,
  tl_channel.device   host,
  tl_channel.host     device
);
  localparam int SLOT_W = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int CNT_W  = 1 << SizeWidth;
  localparam int LOG_BB = $clog2(DataWidth / 8);

  if (host.SourceWidth != HostSourceWidth) begin : g_chk_host_src
    $fatal(1, "host SourceWidth mismatch");
  end
  if (device.SourceWidth != DeviceSourceWidth) begin : g_chk_dev_src
    $fatal(1, "device SourceWidth mismatch");
  end
  if (host.AddrWidth != device.AddrWidth || host.SinkWidth != device.SinkWidth ||
      host.DataWidth != DataWidth || device.DataWidth != DataWidth ||
      host.SizeWidth != SizeWidth || device.SizeWidth != SizeWidth) begin : g_chk_widths
    $fatal(1, "host/device channel width mismatch");
  end
  if (NumSlots > (1 << DeviceSourceWidth) || NumSlots < 1) begin : g_chk_slots
    $fatal(1, "NumSlots out of range");
  end

  // Bursts longer than one beat only when data is carried and exceeds a beat.
  function automatic logic [CNT_W-1:0] beats_m1(input logic [SizeWidth-1:0] size,
                                                input logic has_data);
    if (has_data && int'(size) > LOG_BB)
      beats_m1 = (CNT_W'(1) << (int'(size) - LOG_BB)) - CNT_W'(1);
    else
      beats_m1 = '0;
  endfunction

  logic [NumSlots-1:0]        r_busy;
  logic [HostSourceWidth-1:0] r_src_tab [NumSlots];
  logic [CNT_W-1:0]           r_a_left, r_d_left;
  logic [SLOT_W-1:0]          r_a_slot;

  logic                       w_any_free, w_a_first, w_a_elig, w_a_fire;
  logic [SLOT_W-1:0]          w_free_idx, w_a_slot, w_d_idx;
  logic [CNT_W-1:0]           w_a_beats_m1, w_d_beats_m1;
  logic                       w_d_fire, w_d_last;
  logic [HostSourceWidth-1:0] w_d_host_src;

  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_any_free = 1'b1;
        w_free_idx = SLOT_W'(i);
      end
    end
  end

  assign w_a_first    = (r_a_left == '0);
  assign w_a_slot     = w_a_first ? w_free_idx : r_a_slot;
  assign w_a_elig     = !w_a_first || w_any_free;
  assign w_a_fire     = host.a_valid && host.a_ready;
  assign w_a_beats_m1 = beats_m1(host.a_size, host.a_opcode <= 3'd3);

  assign device.a_valid   = host.a_valid && w_a_elig;
  assign host.a_ready     = device.a_ready && w_a_elig;
  assign device.a_source  = DeviceSourceWidth'(SourceBase) | DeviceSourceWidth'(w_a_slot);
  assign device.a_opcode  = host.a_opcode;
  assign device.a_param   = host.a_param;
  assign device.a_size    = host.a_size;
  assign device.a_address = host.a_address;
  assign device.a_mask    = host.a_mask;
  assign device.a_data    = host.a_data;
  assign device.a_corrupt = host.a_corrupt;

  assign w_d_idx      = SLOT_W'(device.d_source - DeviceSourceWidth'(SourceBase));
  assign w_d_fire     = device.d_valid && host.d_ready;
  assign w_d_beats_m1 = beats_m1(device.d_size, device.d_opcode == 3'd1);
  assign w_d_last     = (r_d_left == '0 && w_d_beats_m1 == '0) || (r_d_left == CNT_W'(1));

  always_comb begin
    w_d_host_src = '0;
    if (int'(w_d_idx) < NumSlots) w_d_host_src = r_src_tab[w_d_idx];
  end

  assign host.d_valid   = device.d_valid;
  assign device.d_ready = host.d_ready;
  assign host.d_source  = w_d_host_src;
  assign host.d_opcode  = device.d_opcode;
  assign host.d_param   = device.d_param;
  assign host.d_size    = device.d_size;
  assign host.d_sink    = device.d_sink;
  assign host.d_denied  = device.d_denied;
  assign host.d_data    = device.d_data;
  assign host.d_corrupt = device.d_corrupt;

  // B, C and E are not supported on an uncached link.
  assign host.b_valid   = 1'b0;
  assign host.b_opcode  = '0;
  assign host.b_param   = '0;
  assign host.b_size    = '0;
  assign host.b_source  = '0;
  assign host.b_address = '0;
  assign host.b_mask    = '0;
  assign host.b_data    = '0;
  assign host.b_corrupt = 1'b0;
  assign host.c_ready   = 1'b0;
  assign host.e_ready   = 1'b0;
  assign device.b_ready   = 1'b1;
  assign device.c_valid   = 1'b0;
  assign device.c_opcode  = '0;
  assign device.c_param   = '0;
  assign device.c_size    = '0;
  assign device.c_source  = '0;
  assign device.c_address = '0;
  assign device.c_data    = '0;
  assign device.c_corrupt = 1'b0;
  assign device.e_valid   = 1'b0;
  assign device.e_sink    = '0;

  wire w_unused = ^{host.b_ready, host.c_valid, host.c_opcode, host.c_param, host.c_size,
                    host.c_source, host.c_address, host.c_data, host.c_corrupt,
                    host.e_valid, host.e_sink, device.b_valid, device.b_opcode,
                    device.b_param, device.b_size, device.b_source, device.b_address,
                    device.b_mask, device.b_data, device.b_corrupt, device.c_ready,
                    device.e_ready};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy   <= '0;
      r_a_left <= '0;
      r_a_slot <= '0;
      r_d_left <= '0;
    end else begin
      if (w_a_fire) begin
        if (w_a_first) begin
          r_busy[w_a_slot] <= 1'b1;
          r_a_slot         <= w_a_slot;
          r_a_left         <= w_a_beats_m1;
        end else begin
          r_a_left <= r_a_left - CNT_W'(1);
        end
      end
      if (w_d_fire) begin
        if (w_d_last) r_busy[w_d_idx] <= 1'b0;
        r_d_left <= (r_d_left == '0) ? w_d_beats_m1 : r_d_left - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_a_fire && w_a_first) r_src_tab[w_a_slot] <= host.a_source;
  end

  a_d_for_busy_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    device.d_valid |-> r_busy[w_d_idx]);
  a_no_c_e: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !host.c_valid && !host.e_valid);
  a_stable_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (host.a_valid && !host.a_ready) |=> (host.a_valid && $stable(host.a_opcode) &&
      $stable(host.a_param) && $stable(host.a_size) && $stable(host.a_source) &&
      $stable(host.a_address) && $stable(host.a_mask) && $stable(host.a_data)));
endmodule
`default_nettype wire

// File: tb/tb_tl_source_remapper.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_tl_source_remapper : directed self-checking bench for tl_source_remapper
// Rev 1.0
//------------------------------------------------------------------------------
module tb_tl_source_remapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] exp_src [8];

  always #5 clk = ~clk;

  tl_channel #(.AddrWidth(32), .DataWidth(64), .SizeWidth(3), .SourceWidth(8), .SinkWidth(1)) h0 ();
  tl_channel #(.AddrWidth(32), .DataWidth(64), .SizeWidth(3), .SourceWidth(3), .SinkWidth(1)) d0 ();
  tl_channel #(.AddrWidth(32), .DataWidth(64), .SizeWidth(3), .SourceWidth(8), .SinkWidth(1)) h1 ();
  tl_channel #(.AddrWidth(32), .DataWidth(64), .SizeWidth(3), .SourceWidth(4), .SinkWidth(1)) d1 ();

  tl_source_remapper #(.HostSourceWidth(8), .DeviceSourceWidth(3), .NumSlots(8),
                       .SourceBase(0), .DataWidth(64), .SizeWidth(3)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .host(h0.device), .device(d0.host));

  tl_source_remapper #(.HostSourceWidth(8), .DeviceSourceWidth(4), .NumSlots(8),
                       .SourceBase(8), .DataWidth(64), .SizeWidth(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .host(h1.device), .device(d1.host));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_a0(input logic v, input logic [2:0] op, input logic [2:0] sz,
                          input logic [7:0] src);
    h0.a_valid = v; h0.a_opcode = op; h0.a_size = sz; h0.a_source = src;
    h0.a_address = {24'h0, src};
  endtask

  task automatic drive_d0(input logic v, input logic [2:0] op, input logic [2:0] sz,
                          input logic [2:0] src);
    d0.d_valid = v; d0.d_opcode = op; d0.d_size = sz; d0.d_source = src;
  endtask

  initial begin
    {h0.a_valid, h0.a_opcode, h0.a_param, h0.a_size, h0.a_source, h0.a_address} = '0;
    {h0.a_mask, h0.a_data, h0.a_corrupt, h0.c_valid, h0.e_valid} = '0;
    {h1.a_valid, h1.a_opcode, h1.a_param, h1.a_size, h1.a_source, h1.a_address} = '0;
    {h1.a_mask, h1.a_data, h1.a_corrupt, h1.c_valid, h1.e_valid} = '0;
    {h0.b_ready, h0.d_ready, h1.b_ready, h1.d_ready} = 4'b1111;
    {d0.a_ready, d0.b_valid, d0.c_ready, d0.e_ready} = 4'b1000;
    {d1.a_ready, d1.b_valid, d1.c_ready, d1.e_ready} = 4'b1000;
    {d0.d_valid, d0.d_opcode, d0.d_param, d0.d_size, d0.d_source, d0.d_sink} = '0;
    {d0.d_denied, d0.d_data, d0.d_corrupt} = '0;
    {d1.d_valid, d1.d_opcode, d1.d_param, d1.d_size, d1.d_source, d1.d_sink} = '0;
    {d1.d_denied, d1.d_data, d1.d_corrupt} = '0;
    exp_src = '{8'h10, 8'h11, 8'h20, 8'h18, 8'h14, 8'h15, 8'h16, 8'h17};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_dev_a_valid", 64'(d0.a_valid), 64'd0);
    check("rst_host_d_valid", 64'(h0.d_valid), 64'd0);
    check("rst_host_b_valid", 64'(h0.b_valid), 64'd0);
    check("rst_dev_c_valid", 64'(d0.c_valid), 64'd0);
    check("rst_dev_e_valid", 64'(d0.e_valid), 64'd0);
    check("rst_host_a_ready", 64'(h0.a_ready), 64'd1);
    check("rst_dev_b_ready", 64'(d0.b_ready), 64'd1);
    check("rst_host_c_ready", 64'(h0.c_ready), 64'd0);

    // Single Get, then response; freed slot reusable only the following cycle
    @(negedge clk); drive_a0(1, 3'd4, 3'd3, 8'hA5); #1;
    check("get_dev_a_valid", 64'(d0.a_valid), 64'd1);
    check("get_dev_a_source", 64'(d0.a_source), 64'd0);
    check("get_host_a_ready", 64'(h0.a_ready), 64'd1);
    @(negedge clk); drive_a0(1, 3'd4, 3'd3, 8'h33); d0.a_ready = 1'b0;
    drive_d0(1, 3'd1, 3'd3, 3'd0); #1;
    check("ackdata_host_d_valid", 64'(h0.d_valid), 64'd1);
    check("ackdata_host_d_source", 64'(h0.d_source), 64'hA5);
    check("no_same_cycle_reuse", 64'(d0.a_source), 64'd1);
    @(negedge clk); drive_d0(0, 3'd0, 3'd0, 3'd0); d0.a_ready = 1'b1; #1;
    check("freed_next_cycle", 64'(d0.a_source), 64'd0);
    @(negedge clk); drive_a0(0, 3'd0, 3'd0, 8'h0); drive_d0(1, 3'd0, 3'd2, 3'd0); #1;
    check("ack_host_d_source", 64'(h0.d_source), 64'h33);
    @(negedge clk); drive_d0(0, 3'd0, 3'd0, 3'd0);

    // Fill the pool, stall, free slot 3
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive_a0(1, 3'd4, 3'd3, 8'(8'h10 + i)); #1;
      check($sformatf("fill_src%0d", i), 64'(d0.a_source), 64'(i));
    end
    @(negedge clk); drive_a0(1, 3'd4, 3'd3, 8'h18); #1;
    check("full_host_a_ready", 64'(h0.a_ready), 64'd0);
    check("full_dev_a_valid", 64'(d0.a_valid), 64'd0);
    @(negedge clk); drive_d0(1, 3'd1, 3'd3, 3'd3); #1;
    check("full_free3_d_source", 64'(h0.d_source), 64'h13);
    check("full_free3_same_cycle", 64'(h0.a_ready), 64'd0);
    @(negedge clk); drive_d0(0, 3'd0, 3'd0, 3'd0); #1;
    check("full_free3_next_ready", 64'(h0.a_ready), 64'd1);
    check("full_free3_reuse", 64'(d0.a_source), 64'd3);

    // Full pool, 4-beat AccessAckData on slot 2, pending A waits for the last beat
    @(negedge clk); drive_a0(1, 3'd4, 3'd3, 8'h20); #1;
    check("full2_stall", 64'(h0.a_ready), 64'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); drive_d0(1, 3'd1, 3'd5, 3'd2); #1;
      check($sformatf("burst_d_src_b%0d", b), 64'(h0.d_source), 64'h12);
      check($sformatf("burst_d_stall_b%0d", b), 64'(h0.a_ready), 64'd0);
    end
    @(negedge clk); drive_d0(0, 3'd0, 3'd0, 3'd0); #1;
    check("full2_ready", 64'(h0.a_ready), 64'd1);
    check("full2_reuse", 64'(d0.a_source), 64'd2);
    @(negedge clk); drive_a0(0, 3'd0, 3'd0, 8'h0);
    for (int i = 0; i < 8; i++) begin
      drive_d0(1, 3'd0, 3'd5, 3'(i)); #1;
      check($sformatf("drain_src%0d", i), 64'(h0.d_source), 64'(exp_src[i]));
      @(negedge clk);
    end
    drive_d0(0, 3'd0, 3'd0, 3'd0);

    // 4-beat PutFull holds one slot; following Get takes slot 1
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); drive_a0(1, 3'd0, 3'd5, 8'h42); h0.a_data = 64'(b + 100); #1;
      check($sformatf("put_src_b%0d", b), 64'(d0.a_source), 64'd0);
      check($sformatf("put_data_b%0d", b), d0.a_data, 64'(b + 100));
    end
    @(negedge clk); drive_a0(1, 3'd4, 3'd3, 8'h43); #1;
    check("get_after_put", 64'(d0.a_source), 64'd1);
    @(negedge clk); drive_a0(0, 3'd0, 3'd0, 8'h0); drive_d0(1, 3'd0, 3'd5, 3'd0); #1;
    check("put_ack_src", 64'(h0.d_source), 64'h42);
    @(negedge clk); drive_d0(1, 3'd1, 3'd3, 3'd1); #1;
    check("get_ack_src", 64'(h0.d_source), 64'h43);
    @(negedge clk); drive_d0(0, 3'd0, 3'd0, 3'd0);

    // SourceBase = 8 instance, including reset mid-operation
    @(negedge clk);
    h1.a_valid = 1'b1; h1.a_opcode = 3'd4; h1.a_size = 3'd3; h1.a_source = 8'h77; #1;
    check("base_first_src", 64'(d1.a_source), 64'd8);
    @(negedge clk); h1.a_valid = 1'b0;
    d1.d_valid = 1'b1; d1.d_opcode = 3'd1; d1.d_size = 3'd3; d1.d_source = 4'd8; #1;
    check("base_d_src", 64'(h1.d_source), 64'h77);
    @(negedge clk); d1.d_valid = 1'b0; h1.a_valid = 1'b1; h1.a_source = 8'h78; #1;
    check("base_reuse", 64'(d1.a_source), 64'd8);
    @(negedge clk); h1.a_source = 8'h79; #1;
    check("base_second", 64'(d1.a_source), 64'd9);
    @(negedge clk); h1.a_valid = 1'b0; rst_n = 1'b0; #1;
    check("base_rst_a_valid", 64'(d1.a_valid), 64'd0);
    @(negedge clk); rst_n = 1'b1; h1.a_valid = 1'b1; h1.a_source = 8'h7A; #1;
    check("base_after_rst", 64'(d1.a_source), 64'd8);
    check("base_after_rst_ready", 64'(h1.a_ready), 64'd1);
    @(negedge clk); h1.a_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tl_source_remapper.md
# tl_source_remapper

Dynamic TileLink source-ID remapper for uncached (TL-UL/TL-UH) links. It compresses a wide or sparse host source space into a small pool of device source IDs. The first beat of each A request takes the lowest free slot, the original host source is stored per slot, and the AccessAck's last D beat restores the host source and frees the slot. It sits between a host port and a crossbar input port where device-side source IDs are scarce, and it backpressures the host when the pool is exhausted.

## Interface
Parameters:
- HostSourceWidth, 8, host-side source width.
- DeviceSourceWidth, 3, device-side source width.
- NumSlots, 1 << DeviceSourceWidth, outstanding-request pool size; range 1..2^DeviceSourceWidth.
- SourceBase, 0, OR-ed onto the slot index to form device.a_source; low clog2(NumSlots) bits must be zero.
- DataWidth, 64, beat width in bits; must match both channels.
- SizeWidth, 3, size field width; must match both channels.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- host  tl_channel.device  -  upstream link, HostSourceWidth.
- device  tl_channel.host  -  downstream link, DeviceSourceWidth.

Elaboration-time $fatal on any of these:
- SourceWidth mismatch on either interface.
- AddrWidth, DataWidth, SizeWidth or SinkWidth mismatch between the two interfaces.
- NumSlots > 2^DeviceSourceWidth.

## Operation
- State:
  - busy[NumSlots] and src_tab[NumSlots][HostSourceWidth].
  - a_beats_left and a_slot: A burst tracker.
  - d_beats_left: D burst tracker.
- Beat count. Beat bytes BB = DataWidth/8.
  - A carries data for opcodes 0-3 (PutFull, PutPartial, Arithmetic, Logical).
  - D carries data for opcode 1 (AccessAckData).
  - Beats = (1<<size)/BB when data is carried and (1<<size) > BB; otherwise 1.
- A channel, first beat (a_beats_left==0):
  - slot = lowest index with busy==0.
  - If no slot is free: host.a_ready=0 and device.a_valid=0.
  - Otherwise pass the beat through with device.a_source = SourceBase | slot.
  - On handshake: busy[slot]<=1, src_tab[slot]<=host.a_source, a_slot<=slot, a_beats_left<=beats-1.
- A channel, later beats (a_beats_left!=0):
  - Use a_slot; no free-slot check.
  - Decrement a_beats_left on each handshake.
- All other A fields pass through unchanged. host.a_ready = device.a_ready while the beat is eligible.
- D channel:
  - Fully combinational pass-through except host.d_source = src_tab[device.d_source - SourceBase].
  - On the last beat handshake (d_beats_left==0 and beats==1, or d_beats_left==1): busy[idx]<=0.
  - First beat of a multi-beat D sets d_beats_left<=beats-1; each later beat decrements it.
- B, C, E unsupported:
  - host.b_valid=0, device.c_valid=0, device.e_valid=0.
  - device.b_ready=1, host.c_ready=0, host.e_ready=0.
- Assertions:
  - D arriving for a non-busy slot.
  - host.c_valid or host.e_valid ever high.
  - A fields changing mid-stall.

## Timing
- Zero added latency on A and D; no registers on the data path.
- Reset clears all busy, a_beats_left and d_beats_left. With host.a_valid=0, all valid outputs are 0.
- Freeing takes effect the cycle after the D handshake. A slot freed in cycle N is allocatable in N+1, never in N.
- A allocation and D free in the same cycle on different slots are both applied. Same slot cannot occur, since the slot is busy until freed.
- When the pool is full, the host sees a_ready=0 until the cycle after a last-beat D handshake.
- No combinational path from host.a_valid to host.a_ready except through device.a_ready.
- Reset mid-burst discards all outstanding state. The environment must also reset the device side.

## Test plan
- Single Get, size 3, host source 0xA5: device sees a_source=0. AccessAckData returns with d_source=0 → host.d_source=0xA5, and busy[0] clears the next cycle.
- NumSlots=8: issue 8 Gets with sources 0x10..0x17 and no responses → device sources 0..7, then the 9th request is stalled (a_ready=0). Ack d_source=3 → the 9th request goes out on source 3 one cycle later.
- PutFullData, size 5, DataWidth 64 (4 beats), source 0x42: all 4 beats carry the same device source. A Get issued mid-burst is not interleaved and takes slot 1 afterwards.
- Get, size 5 → 4-beat AccessAckData: host.d_source is correct on every beat, and the slot is freed only after beat 4.
- Full pool with a same-cycle last-beat D on slot 2 and a pending A: A stays stalled in that cycle and is accepted on slot 2 the next cycle.
- SourceBase=8, DeviceSourceWidth=4, NumSlots=8: the first request goes out with device a_source=8, and the response with d_source=8 maps back correctly. Assert reset mid-operation → all slots free and the next request gets source 8.
